// File: rtl/vga_overlay_gen.sv
// VGA scan-out with frame-buffer latency compensation, bounding box and
// an N-digit seven-segment overlay drawn on top of the grey camera image.
module vga_overlay_gen #(
  parameter int PIXEL_W    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_ACTIVE = 1'b0,
  parameter bit VSYNC_ACTIVE = 1'b0,
  parameter int MEM_LAT    = 1,
  parameter int IDLE_ADDR  = 1,
  parameter int NUM_DIGITS = 2,
  parameter int SEG_S      = 8,
  parameter int DIG_X0     = 10,
  parameter int DIG_Y0     = 10,
  parameter int BOX_L      = 207,
  parameter int BOX_R      = 433,
  parameter int BOX_T      = 127,
  parameter int BOX_B      = 352,
  parameter logic [11:0] BOX_RGB = 12'h0F0,
  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                    clk24,
  input  logic                    rst_n,
  output logic [AW-1:0]           frame_addr,
  input  logic [PIXEL_W-1:0]      frame_pixel,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic                    digit_valid,
  input  logic                    overlay_en,
  input  logic                    box_en,
  output logic [3:0]              vga_red,
  output logic [3:0]              vga_green,
  output logic [3:0]              vga_blue,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int L  = MEM_LAT - 1;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [AW-1:0] addr_cnt;
  logic [31:0]   hc, vc;
  logic          active, hs_raw, vs_raw, fs_raw, h_last, v_last;

  assign hc     = 32'(h);
  assign vc     = 32'(v);
  assign h_last = (hc == 32'(HT - 1));
  assign v_last = (vc == 32'(VT - 1));
  assign active = (hc < 32'(H_ACTIVE)) && (vc < 32'(V_ACTIVE));
  assign hs_raw = (hc >= 32'(H_ACTIVE + H_FP)) && (hc < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw = (vc >= 32'(V_ACTIVE + V_FP)) && (vc < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign fs_raw = (hc == 32'd0) && (vc == 32'd0);
  assign frame_addr = active ? addr_cnt : AW'(IDLE_ADDR);

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      addr_cnt <= '0;
    end else begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      // addr_cnt always holds the address of the next active pixel
      if (h_last && v_last)
        addr_cnt <= '0;
      else if (active)
        addr_cnt <= addr_cnt + 1'b1;
    end
  end

  logic [HW-1:0] h_p   [MEM_LAT];
  logic [VW-1:0] v_p   [MEM_LAT];
  logic          act_p [MEM_LAT];
  logic          hs_p  [MEM_LAT];
  logic          vs_p  [MEM_LAT];
  logic          fs_p  [MEM_LAT];

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        h_p[i]   <= '0;
        v_p[i]   <= '0;
        act_p[i] <= 1'b0;
        hs_p[i]  <= 1'b0;
        vs_p[i]  <= 1'b0;
        fs_p[i]  <= 1'b0;
      end
    end else begin
      h_p[0]   <= h;
      v_p[0]   <= v;
      act_p[0] <= active;
      hs_p[0]  <= hs_raw;
      vs_p[0]  <= vs_raw;
      fs_p[0]  <= fs_raw;
      for (int i = 1; i < MEM_LAT; i++) begin
        h_p[i]   <= h_p[i-1];
        v_p[i]   <= v_p[i-1];
        act_p[i] <= act_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        fs_p[i]  <= fs_p[i-1];
      end
    end
  end

  logic [4*NUM_DIGITS-1:0] pending, shown;

  // Displayed digits only change at frame start so a frame never tears.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '1;
      shown   <= '1;
    end else begin
      if (digit_valid)
        pending <= digit_data;
      if (fs_raw)
        shown <= digit_valid ? digit_data : pending;
    end
  end

  // segment order {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_map(input logic [3:0] code);
    case (code)
      4'd0:    seg_map = 7'b1111110;
      4'd1:    seg_map = 7'b0110000;
      4'd2:    seg_map = 7'b1101101;
      4'd3:    seg_map = 7'b1111001;
      4'd4:    seg_map = 7'b0110011;
      4'd5:    seg_map = 7'b1011011;
      4'd6:    seg_map = 7'b1011111;
      4'd7:    seg_map = 7'b1110000;
      4'd8:    seg_map = 7'b1111111;
      4'd9:    seg_map = 7'b1111011;
      default: seg_map = 7'b0000001;
    endcase
  endfunction

  function automatic logic [11:0] digit_rgb(input logic [3:0] code);
    case (code)
      4'd0:    digit_rgb = 12'hF00;
      4'd1:    digit_rgb = 12'hF80;
      4'd2:    digit_rgb = 12'hFF0;
      4'd3:    digit_rgb = 12'h0F0;
      4'd4:    digit_rgb = 12'h08F;
      4'd5:    digit_rgb = 12'h00F;
      4'd6:    digit_rgb = 12'h808;
      4'd7:    digit_rgb = 12'hFFF;
      4'd8:    digit_rgb = 12'h888;
      4'd9:    digit_rgb = 12'h9B4;
      default: digit_rgb = 12'hF0F;
    endcase
  endfunction

  function automatic logic seg_hit(input logic [6:0] s, input int lx, input int ly);
    seg_hit = (s[6] && ly < SEG_S) ||
              (s[5] && lx >= 4*SEG_S && ly < 5*SEG_S) ||
              (s[4] && lx >= 4*SEG_S && ly >= 4*SEG_S) ||
              (s[3] && ly >= 8*SEG_S) ||
              (s[2] && lx < SEG_S && ly >= 4*SEG_S) ||
              (s[1] && lx < SEG_S && ly < 5*SEG_S) ||
              (s[0] && ly >= 4*SEG_S && ly < 5*SEG_S);
  endfunction

  int          px, py;
  logic        in_cell, box_hit;
  logic [3:0]  code, grey;
  logic [11:0] cell_rgb, rgb_next, rgb;

  assign px = int'(h_p[L]);
  assign py = int'(v_p[L]);

  always_comb begin
    in_cell  = 1'b0;
    cell_rgb = '0;
    code     = '0;
    grey     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!in_cell && px >= DIG_X0 + 6*SEG_S*k && px < DIG_X0 + 6*SEG_S*k + 5*SEG_S &&
          py >= DIG_Y0 && py < DIG_Y0 + 9*SEG_S) begin
        in_cell  = 1'b1;
        code     = shown[4*k +: 4];
        cell_rgb = seg_hit(seg_map(code), px - (DIG_X0 + 6*SEG_S*k), py - DIG_Y0) ?
                   digit_rgb(code) : 12'h000;
      end
    end
    box_hit = ((px == BOX_L || px == BOX_R) && py >= BOX_T && py <= BOX_B) ||
              ((py == BOX_T || py == BOX_B) && px >= BOX_L && px <= BOX_R);
    // narrow pixels repeat their MSBs into the low grey bits
    for (int i = 0; i < 4; i++)
      grey[3-i] = frame_pixel[PIXEL_W-1 - (i % PIXEL_W)];
    if (!act_p[L])
      rgb_next = 12'h000;
    else if (overlay_en && in_cell)
      rgb_next = cell_rgb;
    else if (box_en && box_hit)
      rgb_next = BOX_RGB;
    else
      rgb_next = {grey, grey, grey};
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      rgb         <= '0;
      vga_hsync   <= ~HSYNC_ACTIVE;
      vga_vsync   <= ~VSYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      rgb         <= rgb_next;
      vga_hsync   <= hs_p[L] ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vga_vsync   <= vs_p[L] ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      frame_start <= fs_p[L];
    end
  end

  assign vga_red   = rgb[11:8];
  assign vga_green = rgb[7:4];
  assign vga_blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_overlay_gen.sv
// Directed bench for vga_overlay_gen on a shrunken 80x55 raster with a
// three-cycle frame-buffer model returning the low address bits as pixel data.
module tb_vga_overlay_gen;

  localparam int HT    = 80;
  localparam int FRAME = 80 * 55;

  logic        clk24 = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] frame_addr;
  logic [3:0]  frame_pixel;
  logic [7:0]  digit_data = 8'h00;
  logic        digit_valid = 1'b0;
  logic        overlay_en = 1'b1;
  logic        box_en = 1'b1;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        vga_hsync, vga_vsync, frame_start;

  int checks = 0;
  int failures = 0;
  int cur = 0;
  int n = 0;
  int cnt = 0;

  vga_overlay_gen #(
    .PIXEL_W(4), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .MEM_LAT(3), .IDLE_ADDR(1),
    .NUM_DIGITS(2), .SEG_S(2), .DIG_X0(2), .DIG_Y0(2),
    .BOX_L(6), .BOX_R(40), .BOX_T(6), .BOX_B(30), .BOX_RGB(12'h0F0)
  ) dut (
    .clk24(clk24), .rst_n(rst_n), .frame_addr(frame_addr), .frame_pixel(frame_pixel),
    .digit_data(digit_data), .digit_valid(digit_valid), .overlay_en(overlay_en),
    .box_en(box_en), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
  );

  always #5 clk24 = ~clk24;

  logic [11:0] a_pipe [3];
  always @(posedge clk24) begin
    a_pipe[0] <= frame_addr;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
  end
  assign frame_pixel = a_pipe[2][3:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    chk(tag, {20'h0, vga_red, vga_green, vga_blue}, {20'h0, exp});
  endtask

  task automatic step();
    @(negedge clk24);
    cur = (cur + 1) % FRAME;
  endtask

  task automatic seek(input int x, input int y);
    while (cur != y * HT + x) step();
  endtask

  task automatic sync_frame(output int waited);
    waited = 0;
    do begin
      @(negedge clk24);
      waited++;
    end while (!frame_start && waited < 3 * FRAME);
    if (!frame_start) chk("frame_start_timeout", 32'd0, 32'd1);
    cur = 0;
  endtask

  task automatic strobe(input logic [7:0] d);
    digit_data  = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk24);
    chk_rgb("reset_rgb", 12'h000);
    chk("reset_hsync", {31'h0, vga_hsync}, 32'd1);
    chk("reset_vsync", {31'h0, vga_vsync}, 32'd1);
    chk("reset_frame_start", {31'h0, frame_start}, 32'd0);
    chk("reset_addr", {20'h0, frame_addr}, 32'd0);
    rst_n = 1'b1;
    sync_frame(n);
    chk("first_fs_latency", n, 4);

    // frame 0: dashes, timing, address, box
    chk_rgb("pix_0_0", 12'h000);
    seek(0, 1);  strobe(8'h37);
    seek(37, 1); chk_rgb("grey_37_1", 12'h555);
    seek(67, 3); chk("hs_67", {31'h0, vga_hsync}, 32'd1);
    seek(68, 3); chk("hs_68", {31'h0, vga_hsync}, 32'd0);
    seek(75, 3); chk("hs_75", {31'h0, vga_hsync}, 32'd0);
    seek(76, 3); chk("hs_76", {31'h0, vga_hsync}, 32'd1);
    seek(0, 4);
    cnt = 0;
    for (int i = 0; i < HT; i++) begin
      if (!vga_hsync) cnt++;
      step();
    end
    chk("hs_low_count", cnt, 8);
    seek(70, 5);  chk("addr_hblank", {20'h0, frame_addr}, 32'd1);
    seek(11, 6);  chk_rgb("dash_over_box", 12'h000);
    seek(41, 6);  chk_rgb("box_r_plus1", 12'h999);
    seek(4, 10);  chk_rgb("dash_d0", 12'hF0F);
    seek(16, 10); chk_rgb("dash_d1", 12'hF0F);
    seek(40, 20); chk_rgb("box_right", 12'h0F0);
    seek(30, 30); chk_rgb("box_bottom", 12'h0F0);
    seek(59, 47); chk("addr_last", {20'h0, frame_addr}, 32'd3071);
    seek(60, 47); chk("addr_idle_after_last", {20'h0, frame_addr}, 32'd1);
    seek(63, 47); chk_rgb("grey_last", 12'hFFF);
    seek(64, 47); chk_rgb("blank_rgb", 12'h000);
    seek(0, 49);  chk("vs_49", {31'h0, vga_vsync}, 32'd1);
    seek(0, 50);  chk("vs_50", {31'h0, vga_vsync}, 32'd0);
    seek(10, 50); chk("addr_vblank", {20'h0, frame_addr}, 32'd1);
    seek(79, 51); chk("vs_51", {31'h0, vga_vsync}, 32'd0);
    seek(0, 52);  chk("vs_52", {31'h0, vga_vsync}, 32'd1);
    seek(76, 54); chk("addr_wrap", {20'h0, frame_addr}, 32'd0);
    sync_frame(n);
    chk("frame_period", 4396 + n, FRAME);

    // frame 1: shows 7 and 3
    seek(4, 2);   chk_rgb("d7_a", 12'hFFF);
    seek(11, 6);  chk_rgb("d7_b_over_box", 12'hFFF);
    seek(4, 10);  chk_rgb("d7_g_off", 12'h000);
    seek(16, 10); chk_rgb("d3_g", 12'h0F0);
    seek(14, 14); chk_rgb("d3_e_off", 12'h000);
    seek(23, 14); chk_rgb("d3_c", 12'h0F0);
    seek(0, 20);  box_en = 1'b0;
    seek(40, 20); chk_rgb("box_disabled", 12'h888);
    box_en = 1'b1;
    seek(0, 25);  strobe(8'h12);
    seek(0, 40);  strobe(8'h95);

    // frame 2: later strobe wins, shows 5 and 9
    sync_frame(n);
    seek(4, 10);  chk_rgb("d5_g", 12'h00F);
    seek(16, 10); chk_rgb("d9_g", 12'h9B4);
    seek(2, 14);  chk_rgb("d5_e_off", 12'h000);
    seek(11, 14); chk_rgb("d5_c", 12'h00F);
    seek(14, 14); chk_rgb("d9_e_off", 12'h000);
    seek(76, 54); strobe(8'h48);
    sync_frame(n);
    chk("fs_after_coincident_strobe", n, 3);

    // frame 3: strobe coinciding with the copy is already visible
    seek(4, 10);  chk_rgb("d8_g", 12'h888);
    seek(16, 10); chk_rgb("d4_g", 12'h08F);
    seek(0, 12);  overlay_en = 1'b0;
    seek(6, 16);  chk_rgb("overlay_off_box", 12'h0F0);
    overlay_en = 1'b1;
    seek(6, 18);  chk_rgb("d8_d_over_box", 12'h888);
    seek(26, 20); chk_rgb("grey_pre_reset", 12'hAAA);
    rst_n = 1'b0;
    #1;
    chk_rgb("midreset_rgb", 12'h000);
    chk("midreset_hsync", {31'h0, vga_hsync}, 32'd1);
    chk("midreset_vsync", {31'h0, vga_vsync}, 32'd1);
    chk("midreset_fs", {31'h0, frame_start}, 32'd0);
    chk("midreset_addr", {20'h0, frame_addr}, 32'd0);
    repeat (2) @(negedge clk24);
    rst_n = 1'b1;
    sync_frame(n);
    chk("post_reset_fs_latency", n, 4);
    seek(4, 10);  chk_rgb("post_reset_dash_d0", 12'hF0F);
    seek(16, 10); chk_rgb("post_reset_dash_d1", 12'hF0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_overlay_gen.md
# vga_overlay_gen

Parametrised VGA scan-out engine with an on-screen overlay. It generates the raster timing, issues frame-buffer read addresses, and compensates for a configurable memory read latency. Over the grey-scale camera image it draws an optional bounding box and an N-digit seven-segment classifier result. It sits between the VGA frame buffer and the VGA pins, and is the successor of the single-digit fixed-timing display path.

## Interface
Parameters:
- PIXEL_W, 4: frame-buffer pixel width; 1..8.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing, in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing, in lines.
- HSYNC_ACTIVE / VSYNC_ACTIVE, 0 / 0: sync pulse polarity.
- MEM_LAT, 1: frame-buffer read latency in cycles; 1..4.
- IDLE_ADDR, 1: address driven outside the active area, so it never collides with write address 0.
- NUM_DIGITS, 2: overlay digit count; 1..4.
- SEG_S, 8: segment thickness in pixels.
- DIG_X0 / DIG_Y0, 10 / 10: top-left corner of the digit overlay.
- BOX_L / BOX_R / BOX_T / BOX_B, 207 / 433 / 127 / 352: bounding-box edges, inclusive.
- BOX_RGB, 12'h0F0: box colour.

Ports:
- clk24, in, 1: pixel clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- frame_addr, out, AW = $clog2(H_ACTIVE*V_ACTIVE): read address.
- frame_pixel, in, PIXEL_W: read data, valid MEM_LAT cycles after its address.
- digit_data, in, 4*NUM_DIGITS: digit codes; digit 0 is in the LSBs and is drawn leftmost.
- digit_valid, in, 1: 1-cycle strobe that captures digit_data.
- overlay_en, in, 1: enables the digit overlay.
- box_en, in, 1: enables the bounding box.
- vga_red / vga_green / vga_blue, out, 4 each: colour outputs.
- vga_hsync / vga_vsync, out, 1 each: sync outputs.
- frame_start, out, 1: pulse coincident with pixel (0,0) at the pins.

## Operation
- **Counters.**
  - h counts 0..HT-1 with HT = sum of the H parameters; v increments when h = HT-1 and counts 0..VT-1.
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
- **Address.**
  - frame_addr = v*H_ACTIVE + h while active, otherwise IDLE_ADDR.
  - Maintained by an incrementing register; no multiplier. It resets to 0 on entering v = 0.
- **Alignment.** h, v, active, hsync and vsync are delayed MEM_LAT cycles in a shift pipeline so they meet frame_pixel. The output stage is registered.
- **Digit capture.**
  - digit_valid loads a pending register, synchronously on clk24.
  - pending is copied to the displayed register only at frame start (h = 0, v = 0 at counter stage). This prevents tearing.
  - Of multiple strobes in one frame, the last one wins.
- **Seven-segment geometry.**
  - Digit k occupies a cell of 5S×9S at x0 = DIG_X0 + 6S·k, y = DIG_Y0. Local coordinates (x, y):
  - a: y in [0, S).
  - g: y in [4S, 5S).
  - d: y in [8S, 9S).
  - a, g and d span x in [0, 5S).
  - f: x in [0, S), y in [0, 5S).
  - e: x in [0, S), y in [4S, 9S).
  - b: x in [4S, 5S), y in [0, 5S).
  - c: x in [4S, 5S), y in [4S, 9S).
- **Digit decode.**
  - Codes 0-9 map to standard segments.
  - Codes 10-15 show "-" (g only).
  - Colour per code: 0 F00, 1 F80, 2 FF0, 3 0F0, 4 08F, 5 00F, 6 808, 7 FFF, 8 888, 9 9B4, other F0F.
  - Unlit pixels inside a cell show black while overlay_en = 1.
- **Pixel priority.**
  1. Not active: 0.
  2. Overlay: overlay_en and pixel inside any cell.
  3. Box: box_en and pixel on an edge, i.e. (h = BOX_L or BOX_R, with v in [BOX_T, BOX_B]) or (v = BOX_T or BOX_B, with h in [BOX_L, BOX_R]).
  4. Grey image: g on all three channels. g = frame_pixel[PIXEL_W-1 -: 4] when PIXEL_W ≥ 4, otherwise frame_pixel left-aligned with its MSBs replicated into the low bits.
- **Sync.**
  - hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).

## Timing
- Reset values:
  - counters, rgb and frame_start: 0.
  - syncs: inactive.
  - frame_addr: 0 (pixel (0,0)).
  - pending and displayed digits: all 4'hF, shown as dashes.
- Latency:
  - counter stage to pins: MEM_LAT+1 cycles.
  - colour, sync and frame_start are mutually aligned at every MEM_LAT.
- digit_valid coinciding with the frame-start copy: the new value is displayed in this frame.
- Reset mid-line: everything returns to reset values immediately; the first post-reset line starts at h = 0.
- Wrap: h = HT-1 together with v = VT-1 gives h = v = 0 and addr = 0 on the next cycle.

## Test plan
- **Timing.** Default parameters, free run 2 frames:
  - hsync low for exactly 96 clocks, starting 656 clocks after each line's first active pixel at the pins.
  - vsync low for 2 lines.
  - Frame period 420000 clocks.
- **Address and latency.** MEM_LAT = 3, frame_pixel = low 4 bits of the delayed address:
  - pins show address-derived grey with zero misalignment.
  - frame_addr = IDLE_ADDR during blanking.
  - frame_addr = 307199 at the last active pixel.
- **Digit capture.**
  - Strobe digit_data = 16'h0037 mid-frame: current frame still shows "--"; the next frame shows 7 (FFF) and 3 (0F0).
  - Second strobe in the same frame: the later value is shown.
- **Box priority.** box_en = 1, overlay_en = 1, box moved to overlap digit 0:
  - overlap pixels show the digit colour;
  - box pixels elsewhere show 0F0;
  - (BOX_R+1, BOX_T) shows the image.
- **Reset mid-frame.** Assert rst_n low at h = 300, v = 200:
  - outputs return to reset values within the same cycle;
  - after release, frame_start pulses MEM_LAT+1 cycles later and the digits show dashes.
